// File: rtl/align_arb_pkg.sv
// align_arb_pkg: shared types, constants and helpers for the round-robin
// write-sink arbiter (align_rr_arbiter and its align_rr_pick selector).
package align_arb_pkg;

    // IDLE: output register empty. HOLD: output register full, waiting for accept.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Width of each per-requester grant statistics counter.
    localparam int STAT_CNT_W = 16;

    // Round-robin increment with an explicit compare against n-1, so a
    // requester count that is not a power of two still wraps to 0 correctly.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage : align_arb_pkg

// File: rtl/align_rr_pick.sv
// align_rr_pick: purely combinational round-robin selector. Scans req
// starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
module align_rr_pick
    import align_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic [IDX_W-1:0] scan_idx;

    // Walk the ring once from rr_ptr and latch onto the first requester found.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path through
        // this block can leave a value unassigned and infer a latch.
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        scan_idx  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req[scan_idx]) begin
                any_req         = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
            end
            scan_idx = IDX_W'(rr_wrap_inc(int'(scan_idx), NUM_REQ));
        end
    end

endmodule : align_rr_pick

// File: rtl/align_rr_arbiter.sv
// align_rr_arbiter: shares one valid/accept write sink between NUM_REQ
// requesters with round-robin priority and a registered output stage.
// The sink sees stable valid/data_in/addr/grant_id until it accepts; a new
// beat can be loaded on the same edge the previous one is accepted, so one
// beat per cycle is sustained.
//
// Optional feature (macro ALIGN_ARB_STATS_EN): adds per-requester 16-bit
// saturating grant counters on grant_cnt and a synchronous clear stats_clr.
module align_rr_arbiter
    import align_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    output logic [NUM_REQ-1:0]             req_accept,
    output logic                           valid,
    output logic [DATA_WIDTH-1:0]          data_in,
    output logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           accept,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
`ifdef ALIGN_ARB_STATS_EN
    ,
    input  logic                           stats_clr,
    output logic [NUM_REQ*STAT_CNT_W-1:0]  grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic               load_ok;
    logic               capture;

    align_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .any_req   (any_req)
    );

    // The output register can take a new beat when empty or when its current beat leaves.
    always_comb begin
        load_ok    = (state == IDLE) || accept;
        capture    = load_ok && any_req;
        // Held at zero during reset so no requester sees a handshake that cannot be captured.
        req_accept = (load_ok && !res) ? win_onehot : '0;
    end

    // Arbiter FSM: owns the output register, the state and the round-robin pointer.
    always_ff @(posedge clk or posedge res) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (res) begin
            state    <= IDLE;
            valid    <= 1'b0;
            data_in  <= '0;
            addr     <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else if (load_ok) begin
            if (any_req) begin
                state    <= HOLD;
                valid    <= 1'b1;
                data_in  <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                addr     <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                grant_id <= win_idx;
                rr_ptr   <= IDX_W'(rr_wrap_inc(int'(win_idx), NUM_REQ));
            end else begin
                state <= IDLE;
                valid <= 1'b0;
            end
        end
    end

`ifdef ALIGN_ARB_STATS_EN
    logic [STAT_CNT_W-1:0] cnt_q [NUM_REQ];

    // Per-requester saturating capture counters; a clear wins over an increment.
    always_ff @(posedge clk or posedge res) begin
        // NOTE: these counters are individual registers with a defined start
        // value, not a RAM, so every entry is explicitly reset.
        if (res) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (capture && (cnt_q[win_idx] != '1)) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + STAT_CNT_W'(1);
        end
    end

    // Flatten the counter array onto the packed statistics port.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*STAT_CNT_W +: STAT_CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule : align_rr_arbiter

// File: tb/tb_align_rr_arbiter.sv
// tb_align_rr_arbiter: self-checking bench for align_rr_arbiter. Directed
// scenarios plus randomized traffic, all checked against a behavioural
// model of the sink port and round-robin priority held in the bench.
// Build with ALIGN_ARB_STATS_EN defined to also exercise the counters.
module tb_align_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            res;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_accept;
    logic            valid;
    logic [DW-1:0]   data_in;
    logic [AW-1:0]   addr;
    logic            accept;
    logic [IW-1:0]   grant_id;
`ifdef ALIGN_ARB_STATS_EN
    logic            stats_clr;
    logic [N*16-1:0] grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: what the sink should be looking at, and whose turn is next.
    int          m_ptr;
    bit          m_valid;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    int          m_id;

    always #5 clk = ~clk;

    align_rr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .res        (res),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_addr   (req_addr),
        .req_accept (req_accept),
        .valid      (valid),
        .data_in    (data_in),
        .addr       (addr),
        .accept     (accept),
        .grant_id   (grant_id)
`ifdef ALIGN_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_slice(input int i, input logic [DW-1:0] d, input logic [AW-1:0] a);
        req_data[i*DW +: DW] = d;
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic randomize_slices();
        for (int i = 0; i < N; i++) begin
            set_slice(i, DW'($urandom), AW'($urandom));
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_data  = '0;
        m_addr  = '0;
        m_id    = 0;
    endtask

    // Called at posedge+1 with inputs already driven: checks the handshake,
    // advances one clock, and checks the sink port against the model.
    task automatic tick();
        int            win;
        logic [N-1:0]  exp_acc;
        logic [DW-1:0] cand_d;
        logic [AW-1:0] cand_a;
        #2;
        win = -1;
        if (!m_valid || accept) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        exp_acc = '0;
        cand_d  = '0;
        cand_a  = '0;
        if (win >= 0) begin
            exp_acc[win] = 1'b1;
            cand_d = req_data[win*DW +: DW];
            cand_a = req_addr[win*AW +: AW];
        end
        check("req_accept", 32'(req_accept), 32'(exp_acc));
        @(posedge clk);
        if (!m_valid || accept) begin
            if (win >= 0) begin
                m_valid = 1;
                m_data  = cand_d;
                m_addr  = cand_a;
                m_id    = win;
                m_ptr   = (win + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("valid", 32'(valid), 32'(m_valid));
        if (m_valid) begin
            check("data_in", 32'(data_in), 32'(m_data));
            check("addr", 32'(addr), 32'(m_addr));
            check("grant_id", 32'(grant_id), 32'(m_id));
        end
    endtask

    // Reset with requests pending: the handshake must stay quiet and the port empty.
    task automatic do_reset();
        res       = 1'b1;
        req_valid = '1;
        accept    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data_in), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_req_accept", 32'(req_accept), 32'd0);
`ifdef ALIGN_ARB_STATS_EN
        check("rst_grant_cnt", 32'(grant_cnt == '0), 32'd1);
`endif
        res       = 1'b0;
        req_valid = '0;
        model_reset();
    endtask

    initial begin
        res       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_addr  = '0;
        accept    = 1'b0;
`ifdef ALIGN_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        model_reset();
        do_reset();

        // Single request from requester 2, then its handshake ends.
        set_slice(2, 8'hA5, 4'h3);
        req_valid = 4'b0100;
        accept    = 1'b1;
        tick();
        check("single_valid", 32'(valid), 32'd1);
        check("single_data", 32'(data_in), 32'hA5);
        check("single_addr", 32'(addr), 32'h3);
        check("single_gid", 32'(grant_id), 32'd2);
        req_valid = '0;
        tick();
        check("single_drop", 32'(valid), 32'd0);
        req_valid = '1;
        tick();
        check("single_next_gid", 32'(grant_id), 32'd3);
        req_valid = '0;
        tick();

        // Full contention: strict rotation with valid held high.
        do_reset();
        req_valid = '1;
        accept    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            randomize_slices();
            tick();
            check("contend_gid", 32'(grant_id), 32'(i % N));
            check("contend_valid", 32'(valid), 32'd1);
        end

        // Backpressure: beat frozen while accept is low, then back-to-back load.
        do_reset();
        randomize_slices();
        req_valid = 4'b0101;
        accept    = 1'b1;
        tick();
        accept = 1'b0;
        for (int i = 0; i < 5; i++) begin
            randomize_slices();
            tick();
        end
        accept = 1'b1;
        tick();
        check("bp_next_gid", 32'(grant_id), 32'd2);
        check("bp_next_valid", 32'(valid), 32'd1);

        // Wrap and skip: pointer at 3 with only requesters 0 and 1 active.
        do_reset();
        req_valid = 4'b0100;
        accept    = 1'b1;
        tick();
        req_valid = 4'b0011;
        tick();
        check("wrap_gid0", 32'(grant_id), 32'd0);
        tick();
        check("wrap_gid1", 32'(grant_id), 32'd1);

        // Asynchronous reset while a beat is held.
        do_reset();
        set_slice(2, 8'h5C, 4'hE);
        req_valid = 4'b0100;
        accept    = 1'b0;
        tick();
        req_valid = '0;
        #3;
        res = 1'b1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_gid", 32'(grant_id), 32'd0);
        check("arst_req_accept", 32'(req_accept), 32'd0);
        @(posedge clk);
        #1;
        res = 1'b0;
        model_reset();
        req_valid = '1;
        accept    = 1'b1;
        tick();
        check("arst_restart_gid", 32'(grant_id), 32'd0);

        // Randomized traffic and backpressure against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req_valid = N'($urandom);
            accept    = ($urandom_range(0, 3) != 0);
            randomize_slices();
            tick();
        end

`ifdef ALIGN_ARB_STATS_EN
        // Saturation of requester 1's counter, then a clear that beats an increment.
        do_reset();
        req_valid = 4'b0010;
        accept    = 1'b1;
        repeat (65600) @(posedge clk);
        #1;
        check("stats_sat", 32'(grant_cnt[1*16 +: 16]), 32'hFFFF);
        check("stats_other", 32'(grant_cnt[0*16 +: 16]), 32'd0);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        check("stats_clr", 32'(grant_cnt[1*16 +: 16]), 32'd0);
        @(posedge clk);
        #1;
        check("stats_after_clr", 32'(grant_cnt[1*16 +: 16]), 32'd1);
        req_valid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_align_rr_arbiter
